// File: rtl/core_dispatch_ctrl_pkg.sv
// Shared definitions for the packet dispatch controller: FSM state encoding
// and the default statistics counter width.
package core_dispatch_ctrl_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_e;

    localparam int STATS_W_DEFAULT = 16;

endpackage

// File: rtl/core_dispatch_ctrl_stats.sv
// Saturating dispatch/stall counters for core_dispatch_ctrl.
// Instantiated only when DISPATCH_STATS_EN is defined.
module dispatch_stats
    import core_dispatch_ctrl_pkg::*;
#(
    parameter int STATS_W = STATS_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc_dispatch,
    input  logic               inc_stall,
    output logic [STATS_W-1:0] dispatch_cnt,
    output logic [STATS_W-1:0] stall_cnt
);

    logic [STATS_W-1:0] dispatch_cnt_q, dispatch_cnt_d;
    logic [STATS_W-1:0] stall_cnt_q, stall_cnt_d;

    // Both counters stick at all-ones instead of wrapping.
    always_comb begin
        dispatch_cnt_d = dispatch_cnt_q;
        stall_cnt_d    = stall_cnt_q;
        if (inc_dispatch && (dispatch_cnt_q != '1)) begin
            dispatch_cnt_d = dispatch_cnt_q + STATS_W'(1);
        end
        if (inc_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STATS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dispatch_cnt_q <= '0;
            stall_cnt_q    <= '0;
        end else begin
            dispatch_cnt_q <= dispatch_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign dispatch_cnt = dispatch_cnt_q;
    assign stall_cnt    = stall_cnt_q;

endmodule

// File: rtl/core_dispatch_ctrl.sv
// Claims a ready core from the tag tree and streams one packet to it.
// Optional statistics counters are built when DISPATCH_STATS_EN is defined.
module core_dispatch_ctrl
    import core_dispatch_ctrl_pkg::*;
#(
    parameter int N       = 4,
    parameter int TAG_SZ  = 5,
    parameter int STATS_W = STATS_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [TAG_SZ-1:0]  tag,
    input  logic               rdy,
    output logic               ack,
    input  logic               pkt_valid,
    input  logic               pkt_beat,
    input  logic               pkt_last,
    output logic               stream_en,
    output logic [TAG_SZ-1:0]  sel,
    output logic               done,
    output logic               err,
    output logic [STATS_W-1:0] dispatch_cnt,
    output logic [STATS_W-1:0] stall_cnt
);

    // One extra bit so N itself is representable even when N == 2**TAG_SZ.
    localparam logic [TAG_SZ:0] N_LIM = (TAG_SZ + 1)'(N);

    state_e            state_q, state_d;
    logic [TAG_SZ-1:0] sel_q, sel_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              tag_ok;
    logic              ack_c;
    logic              stream_c;

    assign tag_ok = ({1'b0, tag} < N_LIM);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        done_d   = 1'b0;
        err_d    = err_q;
        ack_c    = 1'b0;
        stream_c = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (rdy && pkt_valid) begin
                    if (tag_ok) begin
                        ack_c   = 1'b1;
                        sel_d   = tag;
                        state_d = ST_STREAM;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (pkt_beat) begin
                    err_d = 1'b1;
                end
            end
            ST_STREAM: begin
                stream_c = 1'b1;
                if (pkt_beat && pkt_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments only; reset is synchronous and wins over the next-state logic.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Handshake outputs are forced low while reset is asserted, before the flops settle.
    assign ack       = ack_c & rst;
    assign stream_en = stream_c & rst;
    assign sel       = sel_q;
    assign done      = done_q;
    assign err       = err_q;

`ifdef DISPATCH_STATS_EN
    logic stall_c;
    assign stall_c = (state_q == ST_IDLE) && pkt_valid && !rdy;

    dispatch_stats #(
        .STATS_W (STATS_W)
    ) u_stats (
        .clk          (clk),
        .rst          (rst),
        .inc_dispatch (ack),
        .inc_stall    (stall_c),
        .dispatch_cnt (dispatch_cnt),
        .stall_cnt    (stall_cnt)
    );
`else
    assign dispatch_cnt = '0;
    assign stall_cnt    = '0;
`endif

endmodule

// File: tb/tb_core_dispatch_ctrl.sv
// Self-checking bench for core_dispatch_ctrl: directed scenarios followed by
// random traffic, all compared against a behavioural packet-level model.
module tb_core_dispatch_ctrl;

    localparam int N       = 6;
    localparam int TAG_SZ  = 5;
    localparam int STATS_W = 4;
    localparam int SAT     = (1 << STATS_W) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic [TAG_SZ-1:0]  tag;
    logic               rdy;
    logic               ack;
    logic               pkt_valid;
    logic               pkt_beat;
    logic               pkt_last;
    logic               stream_en;
    logic [TAG_SZ-1:0]  sel;
    logic               done;
    logic               err;
    logic [STATS_W-1:0] dispatch_cnt;
    logic [STATS_W-1:0] stall_cnt;

    always #5 clk = ~clk;

    core_dispatch_ctrl #(
        .N       (N),
        .TAG_SZ  (TAG_SZ),
        .STATS_W (STATS_W)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .tag          (tag),
        .rdy          (rdy),
        .ack          (ack),
        .pkt_valid    (pkt_valid),
        .pkt_beat     (pkt_beat),
        .pkt_last     (pkt_last),
        .stream_en    (stream_en),
        .sel          (sel),
        .done         (done),
        .err          (err),
        .dispatch_cnt (dispatch_cnt),
        .stall_cnt    (stall_cnt)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: is a packet in flight, where it goes, and what has been seen.
    bit m_busy  = 1'b0;
    bit m_done  = 1'b0;
    bit m_err   = 1'b0;
    int m_sel   = 0;
    int m_disp  = 0;
    int m_stall = 0;

`ifdef DISPATCH_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= SAT) ? SAT : v + 1;
    endfunction

    function automatic int exp_cnt(input int v);
        return STATS_ON ? v : 0;
    endfunction

    // One clock: drive at negedge, compare all outputs, then advance the model at posedge.
    task automatic step(input bit r, input bit rd, input int tg, input bit v,
                        input bit b, input bit l);
        bit exp_ack;
        bit fin;
        @(negedge clk);
        rst       = r;
        rdy       = rd;
        tag       = TAG_SZ'(tg);
        pkt_valid = v;
        pkt_beat  = b;
        pkt_last  = l;
        #1;
        exp_ack = r && !m_busy && rd && v && (tg < N);
        chk("ack", ack, exp_ack);
        chk("stream_en", stream_en, r && m_busy);
        chk("sel", sel, m_sel);
        chk("done", done, m_done);
        chk("err", err, m_err);
        chk("dispatch_cnt", dispatch_cnt, exp_cnt(m_disp));
        chk("stall_cnt", stall_cnt, exp_cnt(m_stall));
        @(posedge clk);
        if (!r) begin
            m_busy = 0; m_done = 0; m_err = 0; m_sel = 0; m_disp = 0; m_stall = 0;
        end else begin
            fin = m_busy && b && l;
            if (!m_busy) begin
                if (rd && v) begin
                    if (tg < N) begin
                        m_busy = 1;
                        m_sel  = tg;
                        m_disp = sat_inc(m_disp);
                    end else begin
                        m_err = 1;
                    end
                end
                if (b) m_err = 1;
                if (v && !rd) m_stall = sat_inc(m_stall);
            end else if (fin) begin
                m_busy = 0;
            end
            m_done = fin;
        end
        #1;
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b0; tag = '0; pkt_valid = 1'b0; pkt_beat = 1'b0; pkt_last = 1'b0;

        // Reset with a valid offer present: ack must stay low.
        step(0, 1, 2, 1, 0, 0);
        step(0, 1, 2, 1, 0, 0);
        chk("rst_sel", sel, 0);
        chk("rst_err", err, 0);
        chk("rst_done", done, 0);

        // Claim tag 2, then stream three beats.
        step(1, 1, 2, 1, 0, 0);
        chk("claim_stream_en", stream_en, 1);
        chk("claim_sel", sel, 2);
        step(1, 1, 2, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 1);
        chk("last_stream_en", stream_en, 0);
        chk("last_done", done, 1);
        chk("last_dispatch_cnt", dispatch_cnt, STATS_ON ? 1 : 0);
        step(1, 0, 0, 0, 0, 0);
        chk("done_one_cycle", done, 0);

        // Back-to-back: tag 1, rdy held, tag 3 acked right after the last beat.
        step(1, 1, 1, 1, 0, 0);
        step(1, 1, 3, 0, 1, 0);
        step(1, 1, 3, 1, 1, 1);
        chk("b2b_idle", stream_en, 0);
        step(1, 1, 3, 1, 0, 0);
        chk("b2b_sel", sel, 3);
        chk("b2b_stream_en", stream_en, 1);
        step(1, 1, 3, 1, 1, 1);
        step(1, 0, 0, 0, 0, 0);

        // Out-of-range tag: no claim, sticky error.
        step(1, 1, 7, 1, 0, 0);
        chk("badtag_err", err, 1);
        chk("badtag_stream_en", stream_en, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 5, 1, 0, 0);
        chk("err_sticky", err, 1);

        // Reset mid-stream after two beats; pkt_valid dropping has no effect.
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("midrst_sel", sel, 0);
        chk("midrst_err", err, 0);
        chk("midrst_cnt", dispatch_cnt, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("midrst_stream_en", stream_en, 0);

        // Beat while idle raises the error.
        step(1, 0, 0, 0, 1, 0);
        chk("idle_beat_err", err, 1);
        step(0, 0, 0, 0, 0, 0);

        // Stall counter saturation.
        for (int i = 0; i < 20; i++) step(1, 0, 0, 1, 0, 0);
        chk("stall_sat", stall_cnt, STATS_ON ? 15 : 0);
        step(1, 0, 0, 1, 0, 0);
        chk("stall_hold", stall_cnt, STATS_ON ? 15 : 0);

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 39) != 0,
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 7),
                 $urandom_range(0, 1) == 1,
                 m_busy ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0),
                 $urandom_range(0, 2) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
